trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
- Interrupt/trap sequencer for the 5-stage RV32I pipeline.
- It is the originator of pipeline redirects: it raises a redirect and a flush request that the top-level PC mux and the hazard/flush logic consume.
- It samples level-sensitive IRQ lines and takes an interrupt precisely at a WB retire boundary. It saves the interrupted PC and cause, steers fetch to the handler vector, and returns on a retiring MRET.

Parameters:
- NUM_IRQ, 4, number of external interrupt lines (1..16).
- VEC_BASE, 32'h0000_0100, handler base address.
- VEC_STRIDE, 4, byte distance between vector slots (vectored mode only).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_irq  in  NUM_IRQ  level interrupt requests.
- i_irq_mask  in  NUM_IRQ  per-line enable; 1 = enabled.
- i_wb_valid  in  1  real instruction retiring in WB this cycle (not a bubble).
- i_wb_next_pc  in  32  architectural next PC of the retiring instruction (branch/jump resolved).
- i_wb_is_mret  in  1  retiring instruction is MRET.
- o_trap_redirect  out  1  1-cycle pulse; fetch loads o_trap_pc; overrides branch pc_sel.
- o_trap_pc  out  32  redirect target.
- o_flush_all  out  1  1-cycle pulse, coincident with redirect; flushes IF/ID, ID/EX, EX/MEM.
- o_irq_ack  out  NUM_IRQ  one-hot pulse on the line being taken.
- o_mepc  out  32  saved return PC.
- o_mcause  out  32  saved cause.
- o_mie  out  1  global interrupt enable.
- o_in_handler  out  1  high from trap entry until the MRET redirect.

Behaviour:
- Reset (async) values:
  - state = IDLE, o_mie = 1, o_mepc = 0, o_mcause = 0.
  - All pulse outputs = 0, o_trap_pc = 0, o_in_handler = 0.
- Pending vector = i_irq & i_irq_mask. Index 0 has the highest priority.
- FSM states: IDLE, ARMED, ENTER, HANDLER, RETURN.
- IDLE:
  - If o_mie and pending != 0, latch the winner index and go to ARMED. Otherwise stay.
  - MRET retiring in IDLE is ignored (no redirect).
- ARMED:
  - If the winner line deasserts or is masked before a retire, abort to IDLE with no side effects.
  - On i_wb_valid: capture o_mepc = i_wb_next_pc and o_mcause = {1'b1, 31'(idx)}, clear o_mie, go to ENTER.
- ENTER (exactly one cycle):
  - Pulse o_trap_redirect, o_flush_all and o_irq_ack[idx].
  - o_trap_pc = handler address.
  - Set o_in_handler, go to HANDLER.
- HANDLER:
  - New IRQs are not taken (no nesting).
  - On i_wb_valid & i_wb_is_mret, go to RETURN.
- RETURN (one cycle):
  - Pulse o_trap_redirect and o_flush_all with o_trap_pc = o_mepc.
  - Set o_mie = 1, clear o_in_handler, go to IDLE.
- Latency: entry redirect is 1 cycle after the qualifying retire; IRQ assertion to redirect is at least 2 cycles.
- Simultaneous events:
  - A branch redirect in the same cycle as a trap redirect: the trap wins.
  - The branch's effect is already captured in i_wb_next_pc.
- Reset asserted in any state returns to the reset values immediately; no pulse is emitted.
- Arithmetic: handler address = VEC_BASE + idx*VEC_STRIDE, computed at 32 bits with wrap-around.

Optional Feature:
- Macro TRAP_VECTORED_EN.
- Defined: o_trap_pc on entry = VEC_BASE + idx*VEC_STRIDE.
- Undefined (direct mode): o_trap_pc on entry = VEC_BASE for every line; the handler reads o_mcause.
- o_mcause encoding and the RETURN behaviour are identical in both modes.

Decomposition:
- trap_pkg:
  - state enum trap_state_e.
  - MCAUSE_IRQ_BIT constant.
  - Opcode constants (R_type, I_type_load, SYSTEM, etc.).
  - MRET funct12 constant 12'h302.
- Sub-module irq_prio_enc:
  - Parameterised NUM_IRQ.
  - Outputs the valid flag, the winner index [3:0] and the one-hot winner.
  - Reused by the future PLIC-lite block.

Test Plan:
1. Reset mid-HANDLER:
   - Stimulus: i_rst while in HANDLER, then release.
   - Response: o_mie = 1, o_in_handler = 0, no redirect pulse; the next IRQ is taken normally.
2. Basic interrupt entry (vectored):
   - Stimulus: i_irq = 4'b0100, mask = 4'hF, retire with next_pc = 32'h0000_0040.
   - Response: next cycle o_trap_redirect = 1, o_trap_pc = 32'h0000_0108, o_mepc = 32'h40, o_mcause = 32'h8000_0002, o_irq_ack = 4'b0100.
3. Priority and masking:
   - Stimulus: i_irq = 4'b1010, mask = 4'b1000.
   - Response: line 3 taken, o_trap_pc = 32'h10C.
   - With mask = 4'h0: no redirect ever.
4. Abort in ARMED:
   - Stimulus: IRQ pulses for 1 cycle with no WB retire (i_wb_valid = 0).
   - Response: FSM returns to IDLE; no redirect; o_mepc unchanged.
5. No nesting, then return:
   - Stimulus: in HANDLER, assert i_irq[0].
   - Response: ignored.
   - Stimulus: then retire MRET.
   - Response: redirect to o_mepc, o_mie = 1; IRQ0 entry follows ≥2 cycles later.
6. Trap over branch:
   - Stimulus: retiring branch with next_pc = 32'h200 while ARMED.
   - Response: o_mepc = 32'h200; the trap redirect wins.
   - With TRAP_VECTORED_EN undefined: o_trap_pc = 32'h100.

Source files
------------

// File: rtl/trap_pkg.sv
// trap_pkg: shared types and constants for the RV32I trap/interrupt sequencer.
//   trap_state_e    - trap sequencer FSM states
//   MCAUSE_IRQ_BIT  - mcause bit marking an interrupt (vs. exception)
//   OPC_*           - RV32I major opcodes
//   FUNCT12_MRET    - funct12 field identifying MRET within SYSTEM
//   vec_addr()      - handler slot address, 32-bit wrap-around
package trap_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        ENTER,
        HANDLER,
        RETURN
    } trap_state_e;

    localparam int unsigned MCAUSE_IRQ_BIT = 31;

    localparam logic [6:0] OPC_R_TYPE      = 7'b0110011;
    localparam logic [6:0] OPC_I_TYPE_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_I_TYPE_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_S_TYPE      = 7'b0100011;
    localparam logic [6:0] OPC_B_TYPE      = 7'b1100011;
    localparam logic [6:0] OPC_JAL         = 7'b1101111;
    localparam logic [6:0] OPC_JALR        = 7'b1100111;
    localparam logic [6:0] OPC_LUI         = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC       = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM      = 7'b1110011;

    localparam logic [11:0] FUNCT12_MRET   = 12'h302;

    // base + idx*stride, truncated to 32 bits
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input int unsigned stride,
                                             input logic [3:0]  idx);
        return base + (32'(idx) * 32'(stride));
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: WB-retire / redirect bus between the pipeline and trap_ctrl.
//   i_wb_valid      - real instruction retiring in WB
//   i_wb_next_pc    - architectural next PC of the retiring instruction
//   i_wb_is_mret    - retiring instruction is MRET
//   o_trap_redirect - 1-cycle pulse: fetch loads o_trap_pc (beats branch pc_sel)
//   o_trap_pc       - redirect target
//   o_flush_all     - 1-cycle pulse with the redirect; flushes IF/ID, ID/EX, EX/MEM
// modport master: trap_ctrl side (originates redirects)
// modport slave : pipeline side (PC mux / hazard logic)
interface trap_ctrl_if;

    logic        i_wb_valid;
    logic [31:0] i_wb_next_pc;
    logic        i_wb_is_mret;
    logic        o_trap_redirect;
    logic [31:0] o_trap_pc;
    logic        o_flush_all;

    modport master (
        input  i_wb_valid,
        input  i_wb_next_pc,
        input  i_wb_is_mret,
        output o_trap_redirect,
        output o_trap_pc,
        output o_flush_all
    );

    modport slave (
        output i_wb_valid,
        output i_wb_next_pc,
        output i_wb_is_mret,
        input  o_trap_redirect,
        input  o_trap_pc,
        input  o_flush_all
    );

endinterface

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: fixed-priority encoder, line 0 highest priority.
//   i_req    [NUM_IRQ] - request vector
//   o_valid            - any request set
//   o_idx    [3:0]     - winning line index (0 when none)
//   o_onehot [NUM_IRQ] - one-hot of the winning line ('0 when none)
module irq_prio_enc #(
    parameter int unsigned NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0] i_req,
    output logic               o_valid,
    output logic [3:0]         o_idx,
    output logic [NUM_IRQ-1:0] o_onehot
);

    always_comb begin
        o_valid  = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (i_req[i] && !o_valid) begin
                o_valid     = 1'b1;
                o_idx       = 4'(i);
                o_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: interrupt/trap sequencer for the 5-stage RV32I pipeline.
// Takes a level IRQ at a WB retire boundary, saves next PC and cause,
// redirects fetch to the handler and returns on a retiring MRET.
// Ports:
//   i_clk, i_rst        - clock, asynchronous active-high reset
//   i_irq, i_irq_mask   - level requests and per-line enables (1 = enabled)
//   bus (master)        - WB retire inputs, redirect/flush outputs
//   o_irq_ack           - one-hot pulse on the line being taken
//   o_mepc, o_mcause    - saved return PC and cause
//   o_mie               - global interrupt enable
//   o_in_handler        - inside a trap handler
// Build option TRAP_VECTORED_EN: defined -> entry PC = VEC_BASE + idx*VEC_STRIDE;
// undefined -> every line enters at VEC_BASE.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int unsigned NUM_IRQ    = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter int unsigned VEC_STRIDE = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic [NUM_IRQ-1:0] i_irq_mask,
    trap_ctrl_if.master        bus,
    output logic [NUM_IRQ-1:0] o_irq_ack,
    output logic [31:0]        o_mepc,
    output logic [31:0]        o_mcause,
    output logic               o_mie,
    output logic               o_in_handler
);

    trap_state_e        state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [NUM_IRQ-1:0] win_q, win_d;
    logic [31:0]        mepc_q, mepc_d;
    logic [31:0]        mcause_q, mcause_d;
    logic               mie_q, mie_d;
    logic               in_handler_q, in_handler_d;

    logic [NUM_IRQ-1:0] pending;
    logic               pend_valid;
    logic [3:0]         pend_idx;
    logic [NUM_IRQ-1:0] pend_onehot;
    logic               win_live;
    logic [31:0]        handler_pc;

    assign pending  = i_irq & i_irq_mask;
    // winner still requesting and still enabled
    assign win_live = |(pending & win_q);

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio (
        .i_req    (pending),
        .o_valid  (pend_valid),
        .o_idx    (pend_idx),
        .o_onehot (pend_onehot)
    );

`ifdef TRAP_VECTORED_EN
    assign handler_pc = vec_addr(VEC_BASE, VEC_STRIDE, idx_q);
`else
    // direct mode: every line uses slot 0; handler decodes o_mcause
    assign handler_pc = vec_addr(VEC_BASE, VEC_STRIDE, 4'd0);
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            win_q        <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            mie_q        <= 1'b1;
            in_handler_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            win_q        <= win_d;
            mepc_q       <= mepc_d;
            mcause_q     <= mcause_d;
            mie_q        <= mie_d;
            in_handler_q <= in_handler_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        win_d        = win_q;
        mepc_d       = mepc_q;
        mcause_d     = mcause_q;
        mie_d        = mie_q;
        in_handler_d = in_handler_q;

        unique case (state_q)
            IDLE: begin
                if (mie_q && pend_valid) begin
                    idx_d   = pend_idx;
                    win_d   = pend_onehot;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                // a vanished winner aborts even if a retire coincides
                if (!win_live) begin
                    state_d = IDLE;
                end else if (bus.i_wb_valid) begin
                    mepc_d                   = bus.i_wb_next_pc;
                    mcause_d                 = 32'(idx_q);
                    mcause_d[MCAUSE_IRQ_BIT] = 1'b1;
                    mie_d                    = 1'b0;
                    state_d                  = ENTER;
                end
            end
            ENTER: begin
                in_handler_d = 1'b1;
                state_d      = HANDLER;
            end
            HANDLER: begin
                if (bus.i_wb_valid && bus.i_wb_is_mret) begin
                    state_d = RETURN;
                end
            end
            RETURN: begin
                mie_d        = 1'b1;
                in_handler_d = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.o_trap_redirect = 1'b0;
        bus.o_flush_all     = 1'b0;
        bus.o_trap_pc       = '0;
        o_irq_ack           = '0;
        case (state_q)
            ENTER: begin
                bus.o_trap_redirect = 1'b1;
                bus.o_flush_all     = 1'b1;
                bus.o_trap_pc       = handler_pc;
                o_irq_ack           = win_q;
            end
            RETURN: begin
                bus.o_trap_redirect = 1'b1;
                bus.o_flush_all     = 1'b1;
                bus.o_trap_pc       = mepc_q;
            end
            default: ;
        endcase
    end

    assign o_mepc       = mepc_q;
    assign o_mcause     = mcause_q;
    assign o_mie        = mie_q;
    assign o_in_handler = in_handler_q;

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  irq;
    logic [3:0]  mask;
    logic [3:0]  ack;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic        mie;
    logic        in_handler;

    int checks = 0;
    int errors = 0;

    trap_ctrl_if bus ();

    trap_ctrl #(
        .NUM_IRQ    (4),
        .VEC_BASE   (32'h0000_0100),
        .VEC_STRIDE (4)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_irq        (irq),
        .i_irq_mask   (mask),
        .bus          (bus),
        .o_irq_ack    (ack),
        .o_mepc       (mepc),
        .o_mcause     (mcause),
        .o_mie        (mie),
        .o_in_handler (in_handler)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_vec(input int unsigned idx);
`ifdef TRAP_VECTORED_EN
        return 32'h100 + 32'(idx) * 32'd4;
`else
        return (idx == 0) ? 32'h100 : 32'h100;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one clock; outputs sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic v, input logic [31:0] pc, input logic mret);
        bus.i_wb_valid   = v;
        bus.i_wb_next_pc = pc;
        bus.i_wb_is_mret = mret;
    endtask

    initial begin
        rst  = 1'b1;
        irq  = '0;
        mask = '0;
        wb(1'b0, 32'h0, 1'b0);
        step();
        step();
        chk("rst_mie",        32'(mie), 32'd1);
        chk("rst_mepc",       mepc, 32'h0);
        chk("rst_mcause",     mcause, 32'h0);
        chk("rst_redirect",   32'(bus.o_trap_redirect), 32'd0);
        chk("rst_flush",      32'(bus.o_flush_all), 32'd0);
        chk("rst_trap_pc",    bus.o_trap_pc, 32'h0);
        chk("rst_in_handler", 32'(in_handler), 32'd0);
        chk("rst_ack",        32'(ack), 32'h0);
        rst = 1'b0;
        step();

        // basic entry on line 2
        irq  = 4'b0100;
        mask = 4'hF;
        step();                                   // IDLE -> ARMED
        chk("armed_no_redirect", 32'(bus.o_trap_redirect), 32'd0);
        wb(1'b1, 32'h0000_0040, 1'b0);
        step();                                   // ARMED -> ENTER
        chk("e2_redirect", 32'(bus.o_trap_redirect), 32'd1);
        chk("e2_flush",    32'(bus.o_flush_all), 32'd1);
        chk("e2_trap_pc",  bus.o_trap_pc, exp_vec(2));
        chk("e2_mepc",     mepc, 32'h0000_0040);
        chk("e2_mcause",   mcause, 32'h8000_0002);
        chk("e2_ack",      32'(ack), 32'h4);
        chk("e2_mie",      32'(mie), 32'd0);
        wb(1'b0, 32'h0, 1'b0);
        irq = '0;
        step();                                   // HANDLER
        chk("h2_redirect",   32'(bus.o_trap_redirect), 32'd0);
        chk("h2_ack",        32'(ack), 32'h0);
        chk("h2_in_handler", 32'(in_handler), 32'd1);

        // no nesting
        irq = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("nest_redirect", 32'(bus.o_trap_redirect), 32'd0);
            chk("nest_ack",      32'(ack), 32'h0);
        end
        wb(1'b1, 32'h0000_0999, 1'b1);
        step();                                   // HANDLER -> RETURN
        chk("ret_redirect", 32'(bus.o_trap_redirect), 32'd1);
        chk("ret_flush",    32'(bus.o_flush_all), 32'd1);
        chk("ret_trap_pc",  bus.o_trap_pc, 32'h0000_0040);
        chk("ret_ack",      32'(ack), 32'h0);
        wb(1'b0, 32'h0, 1'b0);
        step();                                   // IDLE
        chk("idle_mie",        32'(mie), 32'd1);
        chk("idle_in_handler", 32'(in_handler), 32'd0);
        chk("idle_redirect",   32'(bus.o_trap_redirect), 32'd0);
        wb(1'b1, 32'h0000_0044, 1'b0);
        step();                                   // IDLE -> ARMED (IRQ0)
        chk("irq0_armed_redirect", 32'(bus.o_trap_redirect), 32'd0);
        step();                                   // ARMED -> ENTER
        chk("e0_redirect", 32'(bus.o_trap_redirect), 32'd1);
        chk("e0_trap_pc",  bus.o_trap_pc, exp_vec(0));
        chk("e0_mepc",     mepc, 32'h0000_0044);
        chk("e0_mcause",   mcause, 32'h8000_0000);
        chk("e0_ack",      32'(ack), 32'h1);
        wb(1'b0, 32'h0, 1'b0);
        irq = '0;
        step();                                   // HANDLER
        chk("h0_in_handler", 32'(in_handler), 32'd1);

        // asynchronous reset mid-handler
        #2;
        rst = 1'b1;
        #1;
        chk("rh_mie",        32'(mie), 32'd1);
        chk("rh_in_handler", 32'(in_handler), 32'd0);
        chk("rh_redirect",   32'(bus.o_trap_redirect), 32'd0);
        chk("rh_mepc",       mepc, 32'h0);
        step();
        rst = 1'b0;
        step();
        chk("rh_post_redirect", 32'(bus.o_trap_redirect), 32'd0);

        // priority with masking: only line 3 enabled
        irq  = 4'b1010;
        mask = 4'b1000;
        step();                                   // ARMED
        wb(1'b1, 32'h0000_0080, 1'b0);
        step();                                   // ENTER
        chk("e3_redirect", 32'(bus.o_trap_redirect), 32'd1);
        chk("e3_trap_pc",  bus.o_trap_pc, exp_vec(3));
        chk("e3_mcause",   mcause, 32'h8000_0003);
        chk("e3_ack",      32'(ack), 32'h8);
        wb(1'b0, 32'h0, 1'b0);
        irq = '0;
        step();                                   // HANDLER
        wb(1'b1, 32'h0, 1'b1);
        step();                                   // RETURN
        chk("r3_trap_pc", bus.o_trap_pc, 32'h0000_0080);
        wb(1'b0, 32'h0, 1'b0);
        step();                                   // IDLE

        // all lines masked: nothing is taken
        irq  = 4'hF;
        mask = 4'h0;
        wb(1'b1, 32'h0000_0300, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("masked_redirect", 32'(bus.o_trap_redirect), 32'd0);
        end
        chk("masked_mepc", mepc, 32'h0000_0080);
        wb(1'b0, 32'h0, 1'b0);

        // one-cycle IRQ pulse without a retire aborts in ARMED
        mask = 4'hF;
        irq  = 4'b0010;
        step();                                   // ARMED
        irq = '0;
        step();                                   // abort -> IDLE
        wb(1'b1, 32'h0000_0500, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_redirect", 32'(bus.o_trap_redirect), 32'd0);
        end
        chk("abort_mepc",   mepc, 32'h0000_0080);
        chk("abort_mcause", mcause, 32'h8000_0003);
        wb(1'b0, 32'h0, 1'b0);

        // trap over a branch retiring while ARMED
        irq = 4'b0001;
        step();                                   // ARMED
        wb(1'b1, 32'h0000_0200, 1'b0);
        step();                                   // ENTER
        chk("br_redirect", 32'(bus.o_trap_redirect), 32'd1);
        chk("br_mepc",     mepc, 32'h0000_0200);
        chk("br_trap_pc",  bus.o_trap_pc, 32'h0000_0100);
        wb(1'b0, 32'h0, 1'b0);
        irq = '0;
        step();                                   // HANDLER
        wb(1'b1, 32'h0, 1'b1);
        step();                                   // RETURN
        chk("br_ret_pc", bus.o_trap_pc, 32'h0000_0200);
        wb(1'b0, 32'h0, 1'b0);
        step();                                   // IDLE

        // MRET retiring in IDLE is ignored
        wb(1'b1, 32'h0000_0600, 1'b1);
        step();
        chk("idle_mret_redirect", 32'(bus.o_trap_redirect), 32'd0);
        step();
        chk("idle_mret_redirect2", 32'(bus.o_trap_redirect), 32'd0);
        wb(1'b0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
